// File: rtl/ysyx_22041752_mul_issue_pkg.sv
// Shared encodings for the RV64M multiply issue sequencer: op codes (funct3[1:0]),
// sequencer states and the register-file data width.
package ysyx_22041752_mul_issue_pkg;

  localparam int RF_DATA_WD = 64;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_22041752_mul_issue_if.sv
// Signal bundle around the multiply issue block: EXE request, multiplier control
// and MEM-side result. slave = the issue block, master = its surroundings.
interface ysyx_22041752_mul_issue_if
  import ysyx_22041752_mul_issue_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD,
  parameter int RD_WD   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic               in_word;
  logic [DATA_WD-1:0] in_src1;
  logic [DATA_WD-1:0] in_src2;
  logic [RD_WD-1:0]   in_rd;

  logic               mul_valid;
  logic               mul_u;
  logic               mul_su;
  logic               mul_h;
  logic [DATA_WD-1:0] mul_multiplicand;
  logic [DATA_WD-1:0] mul_multiplier;
  logic [DATA_WD-1:0] mul_product;
  logic               mul_out_valid;

  logic               res_valid;
  logic               res_ready;
  logic [DATA_WD-1:0] res_data;
  logic [RD_WD-1:0]   res_rd;

  modport slave (
    input  in_valid, in_op, in_word, in_src1, in_src2, in_rd,
    output in_ready,
    output mul_valid, mul_u, mul_su, mul_h, mul_multiplicand, mul_multiplier,
    input  mul_product, mul_out_valid,
    output res_valid, res_data, res_rd,
    input  res_ready
  );

  modport master (
    output in_valid, in_op, in_word, in_src1, in_src2, in_rd,
    input  in_ready,
    input  mul_valid, mul_u, mul_su, mul_h, mul_multiplicand, mul_multiplier,
    output mul_product, mul_out_valid,
    input  res_valid, res_data, res_rd,
    output res_ready
  );
endinterface

// File: rtl/ysyx_22041752_mul_rcache.sv
// One-entry result cache for the multiply issue block: remembers the last
// completed op and its final (already MULW-adjusted) result.
module ysyx_22041752_mul_rcache
  import ysyx_22041752_mul_issue_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  mul_op_e            wr_op,
  input  logic               wr_word,
  input  logic [DATA_WD-1:0] wr_src1,
  input  logic [DATA_WD-1:0] wr_src2,
  input  logic [DATA_WD-1:0] wr_result,
  input  mul_op_e            rd_op,
  input  logic               rd_word,
  input  logic [DATA_WD-1:0] rd_src1,
  input  logic [DATA_WD-1:0] rd_src2,
  output logic               hit,
  output logic [DATA_WD-1:0] result
);
  typedef struct packed {
    logic               valid;
    mul_op_e            op;
    logic               word;
    logic [DATA_WD-1:0] src1;
    logic [DATA_WD-1:0] src2;
    logic [DATA_WD-1:0] result;
  } entry_t;

  entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (wr_en) begin
      entry_d.valid  = 1'b1;
      entry_d.op     = wr_op;
      entry_d.word   = wr_word;
      entry_d.src1   = wr_src1;
      entry_d.src2   = wr_src2;
      entry_d.result = wr_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign hit = entry_q.valid && (entry_q.op == rd_op) && (entry_q.word == rd_word) &&
               (entry_q.src1 == rd_src1) && (entry_q.src2 == rd_src2);
  assign result = entry_q.result;

endmodule

// File: rtl/ysyx_22041752_mul_issue.sv
// Issue/response sequencer between EXE multiply decode and the iterative multiplier.
// Define YSYX_22041752_MUL_RESULT_CACHE_EN to add a one-entry result cache.
module ysyx_22041752_mul_issue
  import ysyx_22041752_mul_issue_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD,
  parameter int RD_WD   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  ysyx_22041752_mul_issue_if.slave bus
);
  state_e             state_q, state_d;
  mul_op_e            op_q, op_d;
  logic               word_q, word_d;
  logic [DATA_WD-1:0] src1_q, src1_d;
  logic [DATA_WD-1:0] src2_q, src2_d;
  logic [RD_WD-1:0]   rd_q, rd_d;
  logic [DATA_WD-1:0] res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;

  logic               accept;
  logic [DATA_WD-1:0] in_src1_adj, in_src2_adj, product_adj;
  logic               cache_hit;
  logic [DATA_WD-1:0] cache_result;

  function automatic logic [DATA_WD-1:0] sext_w(input logic [DATA_WD-1:0] x);
    return {{(DATA_WD-32){x[31]}}, x[31:0]};
  endfunction

  // A result waiting in DONE frees the slot in the same cycle it is taken.
  assign bus.in_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & bus.res_ready));
  assign accept       = bus.in_valid & bus.in_ready;
  assign in_src1_adj  = bus.in_word ? sext_w(bus.in_src1) : bus.in_src1;
  assign in_src2_adj  = bus.in_word ? sext_w(bus.in_src2) : bus.in_src2;
  assign product_adj  = word_q ? sext_w(bus.mul_product) : bus.mul_product;

  assign bus.mul_valid        = (state_q == BUSY) & ~flush;
  assign bus.mul_u            = (op_q == MUL_OP_MULHU);
  assign bus.mul_su           = (op_q == MUL_OP_MULHSU);
  assign bus.mul_h            = (op_q != MUL_OP_MUL);
  assign bus.mul_multiplicand = src1_q;
  assign bus.mul_multiplier   = src2_q;

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = rd_q;

`ifdef YSYX_22041752_MUL_RESULT_CACHE_EN
  logic mul_done;
  assign mul_done = (state_q == BUSY) & bus.mul_out_valid & ~flush;

  ysyx_22041752_mul_rcache #(.DATA_WD(DATA_WD)) u_rcache (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (mul_done),
    .wr_op     (op_q),
    .wr_word   (word_q),
    .wr_src1   (src1_q),
    .wr_src2   (src2_q),
    .wr_result (product_adj),
    .rd_op     (mul_op_e'(bus.in_op)),
    .rd_word   (bus.in_word),
    .rd_src1   (in_src1_adj),
    .rd_src2   (in_src2_adj),
    .hit       (cache_hit),
    .result    (cache_result)
  );
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // NOTE: every _d first takes its _q value, so no branch leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    rd_d        = rd_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    if (flush) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        BUSY: if (bus.mul_out_valid) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = product_adj;
        end
        DONE: if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        op_d   = mul_op_e'(bus.in_op);
        word_d = bus.in_word;
        src1_d = in_src1_adj;
        src2_d = in_src2_adj;
        rd_d   = bus.in_rd;
        if (cache_hit) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = cache_result;
        end else begin
          state_d     = BUSY;
          res_valid_d = 1'b0;
        end
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
  // NOTE: operand and result latches are reset too, so the result bus reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= MUL_OP_MUL;
      word_q      <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      word_q      <= word_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_mul_issue.sv
// Directed self-checking bench for ysyx_22041752_mul_issue, with a behavioural
// 66-cycle iterative multiplier (early-out on a zero operand) beside the DUT.
module tb_ysyx_22041752_mul_issue;
  import ysyx_22041752_mul_issue_pkg::*;

  localparam int DW = 64;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  ysyx_22041752_mul_issue_if #(.DATA_WD(DW), .RD_WD(RW)) bus ();

  ysyx_22041752_mul_issue #(.DATA_WD(DW), .RD_WD(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Behavioural multiplier: counts 0..65 while mul_valid, done on count 65.
  logic [6:0]   mcnt;
  logic [127:0] ext_a, ext_b, full;

  always @(posedge clk) begin
    if (reset || !bus.mul_valid) mcnt <= '0;
    else                         mcnt <= mcnt + 7'd1;
  end

  always_comb begin
    ext_a = bus.mul_u ? {64'd0, bus.mul_multiplicand}
                      : {{64{bus.mul_multiplicand[63]}}, bus.mul_multiplicand};
    ext_b = (bus.mul_u || bus.mul_su) ? {64'd0, bus.mul_multiplier}
                                      : {{64{bus.mul_multiplier[63]}}, bus.mul_multiplier};
    full  = ext_a * ext_b;
    bus.mul_product   = bus.mul_h ? full[127:64] : full[63:0];
    bus.mul_out_valid = bus.mul_valid && ((bus.mul_multiplicand == 64'd0) ||
                        (bus.mul_multiplier == 64'd0) || (mcnt == 7'd65));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [4:0] rd);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_word  = word;
    bus.in_src1  = s1;
    bus.in_src2  = s2;
    bus.in_rd    = rd;
    #1;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: in_ready=%b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    bus.in_op = 2'd0; bus.in_word = 1'b0; bus.in_src1 = '0; bus.in_src2 = '0; bus.in_rd = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.mul_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: res_valid=%b mul_valid=%b required 0 0", bus.res_valid, bus.mul_valid);
    end
    n_checks++;
    if (bus.res_data !== 64'd0 || bus.res_rd !== 5'd0 || bus.mul_multiplicand !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_regs: res_data=%h res_rd=%0d mcand=%h required 0 0 0",
               bus.res_data, bus.res_rd, bus.mul_multiplicand);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_mul_basic();
    int lat;
    issue(2'd0, 1'b0, 64'd3, 64'd5, 5'd7);
    n_checks++;
    if (bus.mul_valid !== 1'b1 || {bus.mul_u, bus.mul_su, bus.mul_h} !== 3'b000) begin
      n_fail++;
      $display("FAIL mul_ctrl: valid=%b u/su/h=%b required 1 000", bus.mul_valid,
               {bus.mul_u, bus.mul_su, bus.mul_h});
    end
    wait_result(lat);
    n_checks++;
    if (lat != 66) begin n_fail++; $display("FAIL mul_latency: got %0d required 66", lat); end
    n_checks++;
    if (bus.res_data !== 64'd15 || bus.res_rd !== 5'd7) begin
      n_fail++;
      $display("FAIL mul_result: data=%h rd=%0d required 15 7", bus.res_data, bus.res_rd);
    end
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mul_release: res_valid=%b required 0", bus.res_valid); end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a, b, exp;
    logic [2:0]  ctl;
  } vec_t;

  task automatic test_high_ops();
    vec_t v[3];
    int lat;
    v[0] = '{op: 2'd3, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF,
             exp: 64'hFFFF_FFFF_FFFF_FFFE, ctl: 3'b101};
    v[1] = '{op: 2'd1, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF,
             exp: 64'd0, ctl: 3'b001};
    v[2] = '{op: 2'd2, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2,
             exp: 64'hFFFF_FFFF_FFFF_FFFF, ctl: 3'b011};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].op, 1'b0, v[i].a, v[i].b, 5'(10 + i));
      n_checks++;
      if ({bus.mul_u, bus.mul_su, bus.mul_h} !== v[i].ctl) begin
        n_fail++;
        $display("FAIL high_ctrl[%0d]: u/su/h=%b required %b", i, {bus.mul_u, bus.mul_su, bus.mul_h}, v[i].ctl);
      end
      wait_result(lat);
      n_checks++;
      if (lat != 66 || bus.res_data !== v[i].exp || bus.res_rd !== 5'(10 + i)) begin
        n_fail++;
        $display("FAIL high_result[%0d]: lat=%0d data=%h rd=%0d required 66 %h %0d",
                 i, lat, bus.res_data, bus.res_rd, v[i].exp, 10 + i);
      end
      tick();
    end
  endtask

  task automatic test_mulw();
    int lat;
    issue(2'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd1);
    wait_result(lat);
    n_checks++;
    if (bus.res_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL mulw_sext: got %h required fffffffffffffffe", bus.res_data);
    end
    tick();
    issue(2'd0, 1'b1, 64'h0000_0001_0000_0003, 64'd4, 5'd2);
    n_checks++;
    if (bus.mul_multiplicand !== 64'd3) begin
      n_fail++;
      $display("FAIL mulw_operand: mcand=%h required 3", bus.mul_multiplicand);
    end
    wait_result(lat);
    n_checks++;
    if (lat != 66 || bus.res_data !== 64'd12) begin
      n_fail++;
      $display("FAIL mulw_trunc: lat=%0d data=%h required 66 c", lat, bus.res_data);
    end
    tick();
  endtask

  task automatic test_zero_operand();
    issue(2'd0, 1'b0, 64'd0, 64'h1234, 5'd3);
    n_checks++;
    if (bus.mul_valid !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy: mul_valid=%b res_valid=%b required 1 0", bus.mul_valid, bus.res_valid);
    end
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd0 || bus.mul_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: res_valid=%b data=%h mul_valid=%b required 1 0 0",
               bus.res_valid, bus.res_data, bus.mul_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    int lat;
    bit saw_valid;
    issue(2'd0, 1'b0, 64'd5, 64'd9, 5'd5);
    for (int i = 0; i < 30; i++) tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.mul_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: mul_valid=%b in_ready=%b required 0 0", bus.mul_valid, bus.in_ready);
    end
    tick();
    flush = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.res_valid === 1'b1 || bus.mul_valid === 1'b1) saw_valid = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_valid) begin n_fail++; $display("FAIL flush_drop: activity after flush=1 required 0"); end
    bus.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready: got %b required 0", bus.in_ready); end
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accept: mul_valid=%b required 0", bus.mul_valid); end
    issue(2'd0, 1'b0, 64'd2, 64'd7, 5'd6);
    wait_result(lat);
    n_checks++;
    if (lat != 66 || bus.res_data !== 64'd14 || bus.res_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL flush_next: lat=%0d data=%h rd=%0d required 66 e 6", lat, bus.res_data, bus.res_rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.res_ready = 1'b0;
    issue(2'd0, 1'b0, 64'd6, 64'd7, 5'd9);
    wait_result(lat);
    n_checks++;
    if (lat != 66) begin n_fail++; $display("FAIL bp_latency: got %0d required 66", lat); end
    bus.in_valid = 1'b1; bus.in_op = 2'd0; bus.in_word = 1'b0;
    bus.in_src1 = 64'd11; bus.in_src2 = 64'd3; bus.in_rd = 5'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd42 || bus.res_rd !== 5'd9 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: res_valid=%b data=%h rd=%0d in_ready=%b required 1 2a 9 0",
                 i, bus.res_valid, bus.res_data, bus.res_rd, bus.in_ready);
      end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b required 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.mul_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: res_valid=%b mul_valid=%b required 0 1", bus.res_valid, bus.mul_valid);
    end
    wait_result(lat);
    n_checks++;
    if (lat != 66 || bus.res_data !== 64'd33 || bus.res_rd !== 5'd4) begin
      n_fail++;
      $display("FAIL b2b_result: lat=%0d data=%h rd=%0d required 66 21 4", lat, bus.res_data, bus.res_rd);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_high_ops();
    test_mulw();
    test_zero_operand();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_mul_issue.md
Name: ysyx_22041752_mul_issue

Overview:
Issue/response sequencer between the EXE-stage decode of RV64M multiply ops and the iterative ysyx_22041752_mul unit.
- Accepts one multiply op per transaction from EXE via valid/ready and latches its operands.
- Translates the op into mul control signals and holds mul_valid until the multiplier reports done.
- Captures the product, applies MULW sign-extension, and presents the result to the MEM side via valid/ready.
- Handles pipeline flush and back-pressure.

Parameters:
- DATA_WD, 64, operand/result width (equals `ysyx_22041752_RF_DATA_WD).
- RD_WD, 5, destination register tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; kills any in-flight op
- in_valid  in  1  EXE presents a multiply op
- in_ready  out  1  block can accept an op this cycle
- in_op  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU (funct3[1:0])
- in_word  in  1  MULW; legal only with in_op=MUL
- in_src1  in  DATA_WD  rs1 value
- in_src2  in  DATA_WD  rs2 value
- in_rd  in  RD_WD  destination tag, returned with the result
- mul_valid  out  1  to multiplier: operation active
- mul_u  out  1  unsigned×unsigned
- mul_su  out  1  signed rs1 × unsigned rs2
- mul_h  out  1  select high half
- mul_multiplicand  out  DATA_WD  latched rs1 (sign/zero-adjusted for MULW)
- mul_multiplier  out  DATA_WD  latched rs2
- mul_product  in  DATA_WD  multiplier result
- mul_out_valid  in  1  multiplier done (combinational, same cycle)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  DATA_WD  final result
- res_rd  out  RD_WD  destination tag

Behaviour:
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE and clears every output register: res_valid=0, res_data=0, res_rd=0, mul_valid=0, all operand latches 0.
- IDLE:
  - in_ready=1.
  - On in_valid & ~flush: latch op, operands and rd; go to BUSY.
- BUSY:
  - mul_valid = ~flush.
  - Control decode: MUL/MULW → u=0, su=0, h=0; MULH → u=0, su=0, h=1; MULHSU → u=0, su=1, h=1; MULHU → u=1, su=0, h=1.
  - Operand mapping: multiplicand=rs1, multiplier=rs2.
  - MULW: operands are sign-extended from bit 31 before latching.
  - On mul_out_valid: capture the product into res_data; go to DONE.
  - mul_valid is low the next cycle, so the multiplier does not restart.
- DONE:
  - res_valid=1. res_data and res_rd stay stable until the handshake.
  - MULW result = sext(product[31:0]); the sign-extension is applied at capture.
  - res_valid & res_ready → IDLE.
  - in_ready = res_ready, so back-to-back accept is allowed: on simultaneous res handshake and in_valid, go straight to BUSY.
- Latency:
  - Nonzero operands: BUSY lasts 66 cycles (multiplier count 0..65); res_valid first high 66 cycles after the accept edge.
  - Either operand zero: mul_out_valid in the first BUSY cycle; res_valid 1 cycle after accept, with result 0.
- Flush:
  - Any state → IDLE at the next edge. res_valid is deasserted and the result is dropped.
  - mul_valid goes low combinationally in the flush cycle.
  - flush with in_valid in IDLE: nothing is accepted (in_ready forced 0 when flush=1).
- Reset mid-operation: same as flush, plus registers are cleared.
- No overlap: at most one op in flight.

Optional Feature:
- Macro: YSYX_22041752_MUL_RESULT_CACHE_EN.
- Defined:
  - A one-entry cache {valid, op, word, src1, src2, result} is written on every completed, unflushed op.
  - In IDLE, an accepted op that matches the cache entry exactly skips BUSY and goes to DONE at the next edge with the cached result; mul_valid stays 0.
  - The cache is cleared only by reset.
- Undefined: no cache storage; every op goes through BUSY.

Decomposition:
- Shared header/package ysyx_22041752_mycpu.vh holds:
  - op encodings: MUL_OP_MUL/MULH/MULHSU/MULHU;
  - state encodings: IDLE/BUSY/DONE;
  - the existing RF_DATA_WD.
- Optional sub-module ysyx_22041752_mul_rcache holds the cache entry and compare, instantiated only under the macro.
- The multiplier itself is instantiated beside this block in EXE, not inside it.

Test Plan:
- MUL 3×5, res_ready=1 → res_valid after 66 cycles, res_data=15, res_rd echoed.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULH −1×−1 → 0; MULHSU −1×2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE; MULW src1=0x1_0000_0003, src2=4 → 12.
- MUL 0×0x1234 → res_valid 1 cycle after accept, res_data=0, mul_valid high for exactly 1 cycle.
- flush at BUSY cycle 30 → mul_valid low that cycle, no res_valid ever; next op 2×7 is accepted in IDLE and returns 14.
- res_ready held low 5 cycles in DONE → res_valid/res_data stable; in_ready=0; on release with a new in_valid, the next op is accepted in the same cycle.
